vector_load_buffer: RTL
=======================

# vector_load_buffer

Upstream feeder for the reduction ALU. Accepts signed elements one per cycle over a valid/ready stream and assembles them into an N-element vector. Zero-pads short vectors, then presents the vector and pulses `set` for one cycle so the downstream reducer captures it and starts. It stalls the stream until the reducer reports `done`, so only one reduction is ever in flight.

## Interface
Parameters:
- `BITS`, 8, element width (signed two's complement)
- `N`, 64, vector length (elements); N >= 2

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  BITS  signed element
- `in_valid`  in  1  `in_data` is valid
- `in_last`  in  1  qualifies `in_data` as the final element of the vector; sampled only on an accepted beat
- `in_ready`  out  1  buffer accepts an element this cycle
- `vec_out`  out  BITS x N (unpacked, index 0..N-1)  assembled vector; drives the reducer's `in`
- `count`  out  $clog2(N)+1  number of real (non-pad) elements in the current vector
- `set`  out  1  one-cycle start pulse to the reducer
- `alu_done`  in  1  reducer's `done`
- `busy`  out  1  high while a vector is issued and not yet reduced

## Operation
- Accept rule: a beat is accepted when `in_valid && in_ready`. Element k goes to `vec_out[k]`, then `count` increments.
- States:
  - FILL: `in_ready`=1, `set`=0, `busy`=0.
    - Accepted beat with `in_last`=1, or accepted beat that is element N-1 → ISSUE.
    - `in_last` on element N-1 is the same as full.
  - ISSUE: lasts exactly 1 cycle. `set`=1, `in_ready`=0, `busy`=1. `alu_done` is ignored, because it may still be stale-high from the previous run. Next state is WAIT.
  - WAIT: `in_ready`=0, `set`=0, `busy`=1. `vec_out` and `count` are held stable.
    - `alu_done`=1 → FILL. On that same edge, all `vec_out` entries are cleared to 0 and `count` is cleared to 0.
- Padding: entries at index >= `count` read 0 when `set` asserts.
- Overflow is impossible, since `in_ready`=0 outside FILL. Beats offered while `in_ready`=0 are not consumed and must be held by the source.
- `in_last` with `in_valid`=0 has no effect.

## Timing
- Reset (`rst`=1 at an edge):
  - State → FILL; all `vec_out` = 0; `count` = 0; `set` = 0; `busy` = 0.
  - `in_ready` is forced to 0 combinationally while `rst`=1. It is 1 in the first cycle after release.
- Reset mid-FILL or mid-WAIT: the partial or issued vector is discarded. No `set` is generated.
- Latency from the last accepted beat:
  - `set` is high in the very next cycle.
  - `vec_out`/`count` are already final in that cycle, because they are registered on the accepting edge.
- Full-vector fill takes N accepted cycles plus 1 ISSUE cycle.
- Return to FILL: `in_ready`=1 in the cycle after the edge where `alu_done`=1 is sampled in WAIT.
- `alu_done` high in the first WAIT cycle is honoured. The reducer clears `done` on the `set` edge, so a high value here is a genuine completion.
- `count` width $clog2(N)+1 holds N exactly (e.g. 7 bits, value 64 for N=64).
- All outputs are registered, except `in_ready`, which is decoded from state and `rst`.

## Test plan
- Full vector, N=64, BITS=8: stream values k-32 for k=0..63 with `in_valid` always 1.
  - `set` is high for exactly 1 cycle, the cycle after the 64th beat.
  - `vec_out[k]`=k-32 and `count`=64 when `set` is high.
  - `in_ready`=0 from the `set` cycle until `alu_done`.
- Short vector: send 5, -3, 127 with `in_last` on the third beat.
  - `set` pulses; `count`=3; `vec_out[0..2]`=5,-3,127; `vec_out[3..63]`=0.
  - Downstream sum is 129 wrapped to 8 bits = -127.
- Single element: first beat is -128 with `in_last`=1.
  - `count`=1; `vec_out[0]`=-128; all other entries 0; `set` is high the next cycle.
- Stale done and backpressure:
  - Hold `alu_done`=1 through the ISSUE cycle → the block stays in WAIT.
  - Drop `alu_done` for 10 cycles, then raise it → `in_ready` returns 1 the following cycle.
  - The next vector starts with `vec_out` all 0.
  - `in_valid` held high during WAIT consumes no beats.
- Reset mid-fill: accept 20 beats, then assert `rst` for 1 cycle.
  - `count`=0, all `vec_out`=0, no `set`.
  - `in_ready`=1 the cycle after release; a fresh 64-beat vector issues normally.
- Bubbles: 64 beats with `in_valid` toggling 1/0 each cycle.
  - Only valid beats are stored, in order; `set` fires once, after beat 63.

Source files
------------

// File: rtl/vector_load_buffer.sv
// vector_load_buffer
//
// Upstream feeder for the reduction ALU. Collects signed elements from a
// valid/ready stream into an N-entry vector. A vector closes on an accepted
// beat with in_last, or on the beat that fills entry N-1. Entries that
// received no element read 0. The block then pulses set for one cycle and
// holds the vector stable until the reducer reports alu_done, so only one
// reduction is ever in flight.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_data   signed element, BITS wide
//   in_valid  in_data is valid
//   in_last   final element of the vector (sampled on accepted beats only)
//   in_ready  element accepted this cycle (decoded from state and rst)
//   vec_out   assembled vector, N entries of BITS, index 0..N-1
//   count     number of real (non-pad) elements, $clog2(N)+1 bits
//   set       one-cycle start pulse to the reducer
//   alu_done  reducer completion flag
//   busy      a vector is issued and not yet reduced
module vector_load_buffer #(
  parameter int BITS = 8,
  parameter int N    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [BITS-1:0] in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic signed [BITS-1:0] vec_out [N],
  output logic [$clog2(N):0]     count,
  output logic                   set,
  input  logic                   alu_done,
  output logic                   busy
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;
  logic   accept;
  logic   final_beat;
  logic   clear;

  // Next-state and in_ready decode. alu_done is deliberately not looked at
  // in S_ISSUE: it can still be high from the previous reduction, and the
  // reducer only drops it on the set edge.
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    accept     = 1'b0;
    final_beat = 1'b0;
    clear      = 1'b0;
    case (state)
      S_FILL: begin
        in_ready   = !rst;
        accept     = in_valid && !rst;
        final_beat = in_last || (count == CW'(N - 1));
        if (accept && final_beat) begin
          state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          state_nx = S_FILL;
          clear    = 1'b1;
        end
      end
      default: begin
        state_nx = S_FILL;
      end
    endcase
  end

  // State, control outputs and vector storage. set and busy are registered
  // from the next state so they line up with the ISSUE/WAIT cycles. Each
  // element lands in the entry indexed by the current count, so the vector
  // and count are final on the same edge that moves to ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FILL;
      set   <= 1'b0;
      busy  <= 1'b0;
      count <= '0;
      for (int k = 0; k < N; k++) begin
        vec_out[k] <= '0;
      end
    end else begin
      state <= state_nx;
      set   <= (state_nx == S_ISSUE);
      busy  <= (state_nx != S_FILL);
      if (clear) begin
        count <= '0;
        for (int k = 0; k < N; k++) begin
          vec_out[k] <= '0;
        end
      end else if (accept) begin
        count <= count + CW'(1);
        for (int k = 0; k < N; k++) begin
          if (count == CW'(k)) begin
            vec_out[k] <= in_data;
          end
        end
      end
    end
  end

endmodule
